dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Multi-cycle data-memory responder for the MEM stage of the pipelined CPU: it is the memory side of the CPU's load/store request interface. It accepts one word load or store per request, models a configurable access latency, and holds the pipeline with stall_o until the access completes. The CPU MEM-stage request drives it, and stall_o feeds the pipeline-register hold and PC-freeze logic.

Parameters:
ADDR_WIDTH, 10, word-address bits (2^ADDR_WIDTH x 32-bit words of storage)
LATENCY, 3, BUSY cycles per access; legal range 1..15

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous active-high reset
req_i  input  1  MEM-stage access request; held stable by CPU while stall_o=1
we_i  input  1  1=store, 0=load; sampled with req_i
addr_i  input  32  byte address; bits [1:0] must be 0
wdata_i  input  32  store data
stall_o  output  1  pipeline hold request
ack_o  output  1  one-cycle completion pulse
rdata_o  output  32  load result, valid when ack_o=1
err_o  output  1  misaligned access flag, valid when ack_o=1

Behaviour:
- Clock is clk_i. Reset is synchronous and active-high on rst_i. Neither polarity nor synchronicity is configurable.
- Reset: state=IDLE, count=0, ack_o=0, err_o=0, rdata_o=0, latched request cleared. Memory array contents are not cleared.
- Reset mid-operation aborts the access. A store still in BUSY is never written. No ack_o is issued.
- State machine has three states: IDLE, BUSY and DONE.
- IDLE, req_i=0: stall_o=0, remain in IDLE.
- IDLE, req_i=1, addr_i[1:0]=0: stall_o=1 combinationally in the same cycle. Latch we_i, addr_i[ADDR_WIDTH+1:2] and wdata_i. Set count=LATENCY-1 and go to BUSY.
- IDLE, req_i=1, addr_i[1:0]!=0: stall_o=1. Go directly to DONE with err_o=1 and rdata_o=0. No memory access takes place.
- BUSY: stall_o=1. If count!=0, decrement count. If count==0, perform the access at this edge and go to DONE.
  - Store: write the latched data to mem[latched addr].
  - Load: rdata_o <= mem[latched addr].
- DONE: stall_o=0 and ack_o=1 for exactly one cycle, with err_o as set on entry. The CPU advances at the end of this cycle. Always return to IDLE. req_i seen in DONE belongs to the completed access and is ignored.
- Latency: request first seen in cycle 0 gives ack_o in cycle LATENCY+1. stall_o is high in cycles 0..LATENCY. A misaligned request gives ack_o in cycle 1.
- Back-to-back requests: a new request can be accepted in the IDLE cycle immediately after DONE. Minimum spacing is LATENCY+2 cycles.
- Address width: upper address bits [31:ADDR_WIDTH+2] are ignored, so addresses alias modulo 2^ADDR_WIDTH words. No error is raised for this.
- rdata_o holds its last value between loads. A store leaves rdata_o unchanged. err_o clears on leaving DONE.
- Input changes while in BUSY have no effect, because the request is latched on acceptance.
- Load after store to the same address returns the stored data. There is no bypass requirement because accesses are serialized.
- The counter is 4 bits wide. No arithmetic wraps for legal LATENCY values.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles, then req_i=0 for 5 cycles -> stall_o=0, ack_o=0, rdata_o=0 throughout.
- Store then load with LATENCY=3: store 0xDEADBEEF to 0x0000_0010. Required: stall_o high in cycles 0..3 and ack_o in cycle 4. Then load 0x0000_0010. Required: ack_o 4 cycles after its acceptance, with rdata_o=0xDEADBEEF and err_o=0.
- Misaligned store: store to 0x0000_0013 -> stall_o=1 in cycle 0, then ack_o=1 and err_o=1 in cycle 1. A later load of word 0x0000_0010 returns the prior contents unchanged.
- Aliasing with ADDR_WIDTH=10: store 0x12345678 to 0x0000_1004, then load 0x0000_0004 -> rdata_o=0x12345678.
- Reset mid-store: store 0xCAFEF00D to 0x20 and assert rst_i in the first BUSY cycle. Required: no ack_o, and state returns to IDLE. A following load of 0x20 returns the old value, not 0xCAFEF00D.
- Back-to-back with LATENCY=1: two loads with req_i held continuously -> ack_o in cycles 2 and 5. stall_o=0 in cycles 2 and 5 only within cycles 0..5.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the MEM stage.
// Accepts one word load or store per request, spends LATENCY cycles busy,
// then acknowledges for one cycle. Misaligned requests complete in one cycle
// with err_o set and never touch the memory array.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t                  state;
  state_t                  state_next;
  logic [3:0]              count;
  logic                    lat_we;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [31:0]             lat_wdata;
  logic [31:0]             mem [0:(1<<ADDR_WIDTH)-1];
  logic                    misaligned;
  logic                    access_now;
  logic                    unused_addr_bits;

  assign misaligned = (addr_i[1:0] != 2'b00);
  assign access_now = (state == BUSY) && (count == 4'd0);

  // Upper address bits alias onto the storage and are deliberately dropped.
  assign unused_addr_bits = ^addr_i[31:ADDR_WIDTH+2];

  // State register with synchronous reset; reset abandons any access in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection: misaligned requests skip BUSY, DONE always lasts one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_i) begin
          state_next = misaligned ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (count == 4'd0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake outputs: stall covers the accepting cycle and every BUSY cycle.
  always_comb begin
    stall_o = 1'b0;
    ack_o   = 1'b0;
    case (state)
      IDLE:    stall_o = req_i;
      BUSY:    stall_o = 1'b1;
      DONE:    ack_o   = 1'b1;
      default: begin
        stall_o = 1'b0;
        ack_o   = 1'b0;
      end
    endcase
  end

  // Request latch, latency counter, load data and error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count     <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= 32'd0;
      rdata_o   <= 32'd0;
      err_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i) begin
            if (misaligned) begin
              err_o   <= 1'b1;
              rdata_o <= 32'd0;
            end else begin
              lat_we    <= we_i;
              lat_addr  <= addr_i[ADDR_WIDTH+1:2];
              lat_wdata <= wdata_i;
              count     <= LAT_M1;
              err_o     <= 1'b0;
            end
          end
        end
        BUSY: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end else if (!lat_we) begin
            rdata_o <= mem[lat_addr];
          end
        end
        DONE: begin
          err_o <= 1'b0;
        end
        default: begin
          err_o <= 1'b0;
        end
      endcase
    end
  end

  // Storage write; gated by reset so an aborted store never lands.
  always_ff @(posedge clk_i) begin
    if (!rst_i && access_now && lat_we) begin
      mem[lat_addr] <= lat_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: two responders (LATENCY 3 and 1) driven by directed
// vectors, checked every cycle against a transaction-level model, plus
// literal expectations for the key scenarios.
module tb_dmem_responder;

  localparam int AW = 10;

  logic        clk;
  logic        rst;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        stall_v [2];
  logic        ack_v   [2];
  logic [31:0] rdata_v [2];
  logic        err_v   [2];

  int n_tests = 0;
  int n_fail  = 0;

  dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(3)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .stall_o(stall_v[0]),
    .ack_o(ack_v[0]), .rdata_o(rdata_v[0]), .err_o(err_v[0])
  );

  dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .stall_o(stall_v[1]),
    .ack_o(ack_v[1]), .rdata_o(rdata_v[1]), .err_o(err_v[1])
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic int latOf(input int k);
    return (k == 0) ? 3 : 1;
  endfunction

  // Transaction-level model: an accepted request finishes a fixed number of
  // cycles later, at which point its memory effect and result become visible.
  int          cyc = 0;
  bit          armed    [2];
  bit          pend     [2];
  int          due      [2];
  bit          p_mis    [2];
  bit          p_we     [2];
  logic [AW-1:0] p_addr [2];
  logic [31:0] p_data   [2];
  logic [31:0] exp_rd   [2];
  bit          rd_known [2];
  logic [31:0] mm [2][1<<AW];
  bit          mk [2][1<<AW];

  initial begin
    for (int k = 0; k < 2; k++) begin
      armed[k] = 0;
      pend[k]  = 0;
      for (int j = 0; j < (1<<AW); j++) mk[k][j] = 0;
    end
  end

  // Per-cycle comparison of both DUTs against the model, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        armed[k]    = 1;
        pend[k]     = 0;
        exp_rd[k]   = 32'd0;
        rd_known[k] = 1;
      end else if (armed[k]) begin
        logic e_stall, e_ack, e_err;
        e_stall = 0; e_ack = 0; e_err = 0;
        if (pend[k]) begin
          if (cyc < due[k]) begin
            e_stall = 1;
          end else begin
            e_ack = 1;
            e_err = p_mis[k];
            if (p_mis[k]) begin
              exp_rd[k] = 32'd0;
              rd_known[k] = 1;
            end else if (!p_we[k]) begin
              exp_rd[k]   = mm[k][p_addr[k]];
              rd_known[k] = mk[k][p_addr[k]];
            end else begin
              mm[k][p_addr[k]] = p_data[k];
              mk[k][p_addr[k]] = 1;
            end
            pend[k] = 0;
          end
        end else if (req[k]) begin
          e_stall   = 1;
          pend[k]   = 1;
          p_mis[k]  = (addr[k][1:0] != 2'b00);
          p_we[k]   = we[k];
          p_addr[k] = addr[k][AW+1:2];
          p_data[k] = wdata[k];
          due[k]    = cyc + (p_mis[k] ? 1 : latOf(k) + 1);
        end
        checkOutput($sformatf("inst%0d stall cyc%0d", k, cyc), 32'(stall_v[k]), 32'(e_stall));
        checkOutput($sformatf("inst%0d ack cyc%0d", k, cyc), 32'(ack_v[k]), 32'(e_ack));
        checkOutput($sformatf("inst%0d err cyc%0d", k, cyc), 32'(err_v[k]), 32'(e_err));
        if (rd_known[k])
          checkOutput($sformatf("inst%0d rdata cyc%0d", k, cyc), rdata_v[k], exp_rd[k]);
      end
    end
  end

  // One request on instance k; reports ack cycle, stall trace and result.
  task automatic applyStimulus(input int k, input logic w, input logic [31:0] a,
                               input logic [31:0] d, output int ackc,
                               output logic [15:0] stv, output logic [31:0] rd,
                               output logic er);
    @(posedge clk); #1;
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    ackc = -1; stv = '0; rd = '0; er = 1'b0;
    for (int i = 0; i < 40 && ackc < 0; i++) begin
      @(negedge clk);
      if (i < 16) stv[i] = stall_v[k];
      if (ack_v[k]) begin
        ackc = i;
        rd   = rdata_v[k];
        er   = err_v[k];
      end
    end
    @(posedge clk); #1;
    req[k] = 1'b0;
    if (ackc < 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL inst%0d ack timeout: got none, expected within 40 cycles", k);
    end
  endtask

  int          ackc;
  logic [15:0] stv;
  logic [31:0] rd;
  logic        er;
  int          acks;
  int          stalls;
  logic [5:0]  ackb;
  logic [5:0]  stb;

  // Directed scenarios with literal expectations.
  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'd0; wdata[k] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset.
    repeat (5) begin
      @(negedge clk);
      checkOutput("reset idle stall", 32'(stall_v[0]), 32'd0);
      checkOutput("reset idle ack", 32'(ack_v[0]), 32'd0);
      checkOutput("reset idle rdata", rdata_v[0], 32'd0);
    end

    // Store then load, LATENCY 3.
    applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, ackc, stv, rd, er);
    checkOutput("store ack cycle", ackc, 32'd4);
    checkOutput("store stall trace", 32'(stv[4:0]), 32'h0F);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, ackc, stv, rd, er);
    checkOutput("load ack cycle", ackc, 32'd4);
    checkOutput("load rdata", rd, 32'hDEADBEEF);
    checkOutput("load err", 32'(er), 32'd0);

    // Misaligned store leaves memory untouched.
    applyStimulus(0, 1'b1, 32'h13, 32'h11111111, ackc, stv, rd, er);
    checkOutput("misaligned ack cycle", ackc, 32'd1);
    checkOutput("misaligned err", 32'(er), 32'd1);
    checkOutput("misaligned stall trace", 32'(stv[1:0]), 32'h1);
    checkOutput("misaligned rdata", rd, 32'd0);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, ackc, stv, rd, er);
    checkOutput("post-misaligned load", rd, 32'hDEADBEEF);

    // Address aliasing modulo 1024 words.
    applyStimulus(0, 1'b1, 32'h1004, 32'h12345678, ackc, stv, rd, er);
    applyStimulus(0, 1'b0, 32'h0004, 32'h0, ackc, stv, rd, er);
    checkOutput("alias load", rd, 32'h12345678);

    // Reset during the first BUSY cycle of a store.
    applyStimulus(0, 1'b1, 32'h20, 32'h55AA55AA, ackc, stv, rd, er);
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'hCAFEF00D;
    @(posedge clk); #1;
    rst = 1'b1; req[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    acks = 0; stalls = 0;
    repeat (6) begin
      @(negedge clk);
      acks   += int'(ack_v[0]);
      stalls += int'(stall_v[0]);
    end
    checkOutput("abort ack count", acks, 32'd0);
    checkOutput("abort stall count", stalls, 32'd0);
    checkOutput("abort rdata cleared", rdata_v[0], 32'd0);
    applyStimulus(0, 1'b0, 32'h20, 32'h0, ackc, stv, rd, er);
    checkOutput("abort old value kept", rd, 32'h55AA55AA);

    // Back-to-back loads, LATENCY 1, request held throughout.
    applyStimulus(1, 1'b1, 32'h40, 32'hA5A50001, ackc, stv, rd, er);
    checkOutput("lat1 store ack cycle", ackc, 32'd2);
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h40; wdata[1] = 32'h0;
    ackb = '0; stb = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ackb[i] = ack_v[1];
      stb[i]  = stall_v[1];
      if (ack_v[1]) checkOutput($sformatf("b2b rdata cycle %0d", i), rdata_v[1], 32'hA5A50001);
    end
    @(posedge clk); #1;
    req[1] = 1'b0;
    checkOutput("b2b ack trace", 32'(ackb), 32'h24);
    checkOutput("b2b stall trace", 32'(stb), 32'h1B);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
